// File: rtl/cordic_prefold_pipe.sv
// Pre-rotation front end for the CORDIC core.
// Folds each sample into the core's convergence range (vectoring: quadrant 1,
// rotation: z in [-pi/2, +pi/2] with a matching pre-rotation of x/y).
// The fold is registered into stage 1. Stages 2..STAGES are delay stages.
// Each stage has its own valid bit, so bubbles collapse under backpressure.
module cordic_prefold_pipe #(
    parameter int W      = 16,
    parameter int ZW     = 18,
    parameter int TAG_W  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [W-1:0]     x_in,
    input  logic [W-1:0]     y_in,
    input  logic [ZW-1:0]    z_in,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     x_out,
    output logic [W-1:0]     y_out,
    output logic [ZW-1:0]    z_out,
    output logic [2:0]       quadrant_out,
    output logic             mode_out,
    output logic             sat_out,
    output logic [TAG_W-1:0] tag_out
);

    // Quadrant codes: 1..4 for vectoring, 0/5/6 for rotation.
    localparam logic [2:0] QUAD_PASS    = 3'd0;
    localparam logic [2:0] QUAD_1       = 3'd1;
    localparam logic [2:0] QUAD_2       = 3'd2;
    localparam logic [2:0] QUAD_3       = 3'd3;
    localparam logic [2:0] QUAD_4       = 3'd4;
    localparam logic [2:0] QUAD_ROT_POS = 3'd5;
    localparam logic [2:0] QUAD_ROT_NEG = 3'd6;

    localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] MAX_VAL = {1'b0, {(W-1){1'b1}}};

    // pi/2 in binary-angle format, one guard bit wide so +/- Q never wraps.
    localparam logic signed [ZW:0] QTR     = {3'b001, {(ZW-2){1'b0}}};
    localparam logic signed [ZW:0] NEG_QTR = -QTR;

    typedef struct packed {
        logic [W-1:0]     x;
        logic [W-1:0]     y;
        logic [ZW-1:0]    z;
        logic [2:0]       quad;
        logic             mode;
        logic             sat;
        logic [TAG_W-1:0] tag;
    } stage_t;

    stage_t            fold;
    stage_t            stage_q [1:STAGES];
    logic [STAGES:1]   valid;
    logic [STAGES:1]   stage_ready;

    // Saturating negations. Only the most negative value can overflow.
    logic [W-1:0]      neg_x;
    logic [W-1:0]      neg_y;
    logic              sat_x;
    logic              sat_y;

    assign sat_x = (x_in == MIN_VAL);
    assign sat_y = (y_in == MIN_VAL);
    assign neg_x = sat_x ? MAX_VAL : -x_in;
    assign neg_y = sat_y ? MAX_VAL : -y_in;

    // Angle arithmetic in ZW+1 bits. The folded result always fits in ZW bits,
    // so the guard bit of the sum and difference is dropped.
    logic signed [ZW:0] z_ext;
    logic signed [ZW:0] z_sub;
    logic signed [ZW:0] z_add;
    logic               unused_z_msbs;

    assign z_ext         = {z_in[ZW-1], z_in};
    assign z_sub         = z_ext - QTR;
    assign z_add         = z_ext + QTR;
    assign unused_z_msbs = z_sub[ZW] ^ z_add[ZW];

    // Fold the incoming sample into the core's convergence range.
    always_comb begin
        // NOTE: every field gets a default before the case, so no path leaves
        // a field unassigned and no latch is inferred.
        fold      = '0;
        fold.x    = x_in;
        fold.y    = y_in;
        fold.z    = z_in;
        fold.quad = QUAD_PASS;
        fold.mode = in_mode;
        fold.sat  = 1'b0;
        fold.tag  = tag_in;
        if (!in_mode) begin
            case ({x_in[W-1], y_in[W-1]})
                2'b00: fold.quad = QUAD_1;
                2'b01: begin
                    fold.x    = neg_y;
                    fold.y    = x_in;
                    fold.sat  = sat_y;
                    fold.quad = QUAD_4;
                end
                2'b10: begin
                    fold.x    = y_in;
                    fold.y    = neg_x;
                    fold.sat  = sat_x;
                    fold.quad = QUAD_2;
                end
                default: begin
                    fold.x    = neg_x;
                    fold.y    = neg_y;
                    fold.sat  = sat_x | sat_y;
                    fold.quad = QUAD_3;
                end
            endcase
        end else if (z_ext >= QTR) begin
            fold.x    = neg_y;
            fold.y    = x_in;
            fold.sat  = sat_y;
            fold.z    = z_sub[ZW-1:0];
            fold.quad = QUAD_ROT_POS;
        end else if (z_ext < NEG_QTR) begin
            fold.x    = y_in;
            fold.y    = neg_x;
            fold.sat  = sat_x;
            fold.z    = z_add[ZW-1:0];
            fold.quad = QUAD_ROT_NEG;
        end
    end

    // Stage k can accept when downstream is ready or any stage from k onward
    // is empty: the flattened form of "empty or the next stage advances".
    always_comb begin
        stage_ready = '0;
        for (int k = 1; k <= STAGES; k++) begin
            stage_ready[k] = out_ready;
            for (int j = k; j <= STAGES; j++) begin
                stage_ready[k] = stage_ready[k] | ~valid[j];
            end
        end
    end

    assign in_ready = stage_ready[1];

    // Advance valid bits and data through the stages; stalled stages hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
            // NOTE: the data registers are reset too, because the outputs
            // must read as zero after reset, not only out_valid.
            for (int k = 1; k <= STAGES; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments let every stage sample the
            // previous stage's old value on the same edge.
            if (stage_ready[1]) begin
                valid[1] <= in_valid;
            end
            if (stage_ready[1] && in_valid) begin
                stage_q[1] <= fold;
            end
            for (int k = 2; k <= STAGES; k++) begin
                if (stage_ready[k]) begin
                    valid[k] <= valid[k-1];
                end
                if (stage_ready[k] && valid[k-1]) begin
                    stage_q[k] <= stage_q[k-1];
                end
            end
        end
    end

    assign out_valid    = valid[STAGES];
    assign x_out        = stage_q[STAGES].x;
    assign y_out        = stage_q[STAGES].y;
    assign z_out        = stage_q[STAGES].z;
    assign quadrant_out = stage_q[STAGES].quad;
    assign mode_out     = stage_q[STAGES].mode;
    assign sat_out      = stage_q[STAGES].sat;
    assign tag_out      = stage_q[STAGES].tag;

endmodule

// File: tb/tb_cordic_prefold_pipe.sv
// Directed bench for cordic_prefold_pipe with hand-computed expected values.
module tb_cordic_prefold_pipe;

    localparam int W      = 16;
    localparam int ZW     = 18;
    localparam int TAG_W  = 4;
    localparam int STAGES = 2;

    typedef struct packed {
        int mode;
        int x;
        int y;
        int z;
        int ex;
        int ey;
        int ez;
        int eq;
        int esat;
    } fold_vec_t;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    in_valid;
    logic                    in_ready;
    logic                    in_mode;
    logic signed [W-1:0]     x_in;
    logic signed [W-1:0]     y_in;
    logic signed [ZW-1:0]    z_in;
    logic [TAG_W-1:0]        tag_in;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [W-1:0]     x_out;
    logic signed [W-1:0]     y_out;
    logic signed [ZW-1:0]    z_out;
    logic [2:0]              quadrant_out;
    logic                    mode_out;
    logic                    sat_out;
    logic [TAG_W-1:0]        tag_out;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic signed [W-1:0]  cap_x;
    logic signed [W-1:0]  cap_y;
    logic signed [ZW-1:0] cap_z;
    logic [2:0]           cap_q;
    logic                 cap_mode;
    logic                 cap_sat;
    logic                 cap_seen;
    logic [TAG_W-1:0]     cap_tag;
    int                   cap_lat;

    cordic_prefold_pipe #(
        .W(W), .ZW(ZW), .TAG_W(TAG_W), .STAGES(STAGES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_mode(in_mode),
        .x_in(x_in),
        .y_in(y_in),
        .z_in(z_in),
        .tag_in(tag_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .x_out(x_out),
        .y_out(y_out),
        .z_out(z_out),
        .quadrant_out(quadrant_out),
        .mode_out(mode_out),
        .sat_out(sat_out),
        .tag_out(tag_out)
    );

    always #5 clk = ~clk;

    // Push one sample into an empty pipe with out_ready high, wait (bounded)
    // for it to appear and capture the outputs and the latency in cycles.
    task automatic run_one(input logic mode, input logic signed [W-1:0] x,
                           input logic signed [W-1:0] y, input logic signed [ZW-1:0] z,
                           input logic [TAG_W-1:0] tag);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_mode   = mode;
        x_in      = x;
        y_in      = y;
        z_in      = z;
        tag_in    = tag;
        @(posedge clk);
        cap_lat = 1;
        #1;
        in_valid = 1'b0;
        while (!out_valid && cap_lat < 20) begin
            @(posedge clk);
            cap_lat++;
            #1;
        end
        cap_seen = out_valid;
        cap_x    = x_out;
        cap_y    = y_out;
        cap_z    = z_out;
        cap_q    = quadrant_out;
        cap_mode = mode_out;
        cap_sat  = sat_out;
        cap_tag  = tag_out;
    endtask

    task automatic test_reset();
        #3;
        total_cnt++;
        if ({out_valid, x_out, y_out, z_out, quadrant_out, mode_out, sat_out, tag_out} !== '0)
            $display("FAIL reset_held: out_valid=%0b x=%0d y=%0d z=%0d q=%0d, want all 0",
                     out_valid, x_out, y_out, z_out, quadrant_out);
        else
            pass_cnt++;
        #20 rst = 1'b0;
        @(negedge clk);
        total_cnt++;
        if ({out_valid, in_ready} !== 2'b01)
            $display("FAIL reset_release: out_valid=%0b in_ready=%0b, want 0/1", out_valid, in_ready);
        else
            pass_cnt++;
        total_cnt++;
        if ({x_out, y_out, z_out, quadrant_out, mode_out, sat_out, tag_out} !== '0)
            $display("FAIL reset_outputs: x=%0d y=%0d z=%0d q=%0d mode=%0b sat=%0b tag=%0d, want all 0",
                     x_out, y_out, z_out, quadrant_out, mode_out, sat_out, tag_out);
        else
            pass_cnt++;
    endtask

    task automatic test_vectoring();
        fold_vec_t tbl [4];
        tbl = '{'{0,  100,  -50, 1234,  50, 100, 1234, 4, 0},
                '{0, -100,   50, 1234,  50, 100, 1234, 2, 0},
                '{0, -100,  -50, 1234, 100,  50, 1234, 3, 0},
                '{0,    7,    9, 1234,   7,   9, 1234, 1, 0}};
        for (int i = 0; i < 4; i++) begin
            run_one(tbl[i].mode[0], W'(tbl[i].x), W'(tbl[i].y), ZW'(tbl[i].z), TAG_W'(i));
            total_cnt++;
            if (cap_seen !== 1'b1 || cap_lat != STAGES)
                $display("FAIL vec_latency[%0d]: seen=%0b latency=%0d, want 1/%0d", i, cap_seen, cap_lat, STAGES);
            else
                pass_cnt++;
            total_cnt++;
            if ({cap_x, cap_y, cap_z, cap_q, cap_mode, cap_sat, cap_tag} !==
                {W'(tbl[i].ex), W'(tbl[i].ey), ZW'(tbl[i].ez), 3'(tbl[i].eq), tbl[i].mode[0], tbl[i].esat[0], TAG_W'(i)})
                $display("FAIL vec[%0d]: got x=%0d y=%0d z=%0d q=%0d mode=%0b sat=%0b tag=%0d, want x=%0d y=%0d z=%0d q=%0d mode=%0d sat=%0d tag=%0d",
                         i, cap_x, cap_y, cap_z, cap_q, cap_mode, cap_sat, cap_tag,
                         tbl[i].ex, tbl[i].ey, tbl[i].ez, tbl[i].eq, tbl[i].mode, tbl[i].esat, i);
            else
                pass_cnt++;
        end
    endtask

    task automatic test_saturation();
        fold_vec_t tbl [4];
        tbl = '{'{0, -32768,     -1, 0, 32767,     1, 0, 3, 1},
                '{0,      5,      5, 0,     5,     5, 0, 1, 0},
                '{0,    100, -32768, 0, 32767,   100, 0, 4, 1},
                '{0, -32768,      7, 0,     7, 32767, 0, 2, 1}};
        for (int i = 0; i < 4; i++) begin
            run_one(tbl[i].mode[0], W'(tbl[i].x), W'(tbl[i].y), ZW'(tbl[i].z), TAG_W'(i + 4));
            total_cnt++;
            if (cap_seen !== 1'b1 ||
                {cap_x, cap_y, cap_z, cap_q, cap_mode, cap_sat, cap_tag} !==
                {W'(tbl[i].ex), W'(tbl[i].ey), ZW'(tbl[i].ez), 3'(tbl[i].eq), tbl[i].mode[0], tbl[i].esat[0], TAG_W'(i + 4)})
                $display("FAIL sat[%0d]: got seen=%0b x=%0d y=%0d z=%0d q=%0d sat=%0b tag=%0d, want x=%0d y=%0d z=%0d q=%0d sat=%0d tag=%0d",
                         i, cap_seen, cap_x, cap_y, cap_z, cap_q, cap_sat, cap_tag,
                         tbl[i].ex, tbl[i].ey, tbl[i].ez, tbl[i].eq, tbl[i].esat, i + 4);
            else
                pass_cnt++;
        end
    endtask

    task automatic test_rotation();
        fold_vec_t tbl [9];
        tbl = '{'{1, 1000,      0,  100000,     0,  1000,  34464, 5, 0},
                '{1, 1000,      0, -100000,     0, -1000, -34464, 6, 0},
                '{1, 1000,      0,   65535,  1000,     0,  65535, 0, 0},
                '{1, 1000,      0,   65536,     0,  1000,      0, 5, 0},
                '{1, 1000,      0,  -65536,  1000,     0, -65536, 0, 0},
                '{1, 1000,      0,  -65537,     0, -1000,     -1, 6, 0},
                '{1,    0, -32768,  100000, 32767,     0,  34464, 5, 1},
                '{1,    3,     -4,  131071,     4,     3,  65535, 5, 0},
                '{1,    3,     -4, -131072,    -4,    -3, -65536, 6, 0}};
        for (int i = 0; i < 9; i++) begin
            run_one(tbl[i].mode[0], W'(tbl[i].x), W'(tbl[i].y), ZW'(tbl[i].z), TAG_W'(i));
            total_cnt++;
            if (cap_seen !== 1'b1 ||
                {cap_x, cap_y, cap_z, cap_q, cap_mode, cap_sat, cap_tag} !==
                {W'(tbl[i].ex), W'(tbl[i].ey), ZW'(tbl[i].ez), 3'(tbl[i].eq), tbl[i].mode[0], tbl[i].esat[0], TAG_W'(i)})
                $display("FAIL rot[%0d]: got seen=%0b x=%0d y=%0d z=%0d q=%0d mode=%0b sat=%0b, want x=%0d y=%0d z=%0d q=%0d mode=1 sat=%0d",
                         i, cap_seen, cap_x, cap_y, cap_z, cap_q, cap_mode, cap_sat,
                         tbl[i].ex, tbl[i].ey, tbl[i].ez, tbl[i].eq, tbl[i].esat);
            else
                pass_cnt++;
        end
    endtask

    // Eight tagged samples, alternating vectoring/rotation, with out_ready
    // cycling 1,0,0,1. A model of pipe occupancy predicts in_ready.
    task automatic test_backpressure();
        int   sent = 0;
        int   recv = 0;
        int   cyc  = 0;
        int   exp_x, exp_y, exp_z, exp_q;
        int   extra = 0;
        logic exp_ready;
        logic held = 1'b0;
        logic [W+W+ZW+3+TAG_W:0] held_val = '0;
        while (recv < 8 && cyc < 200) begin
            @(posedge clk);
            #1;
            out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            in_valid  = (sent < 8);
            in_mode   = sent[0];
            x_in      = W'(sent * 10 + 1);
            y_in      = W'(sent + 1);
            z_in      = sent[0] ? ZW'(100000) : ZW'(0);
            tag_in    = TAG_W'(sent);
            @(negedge clk);
            exp_ready = !((sent - recv) == STAGES && !out_ready);
            total_cnt++;
            if (in_ready !== exp_ready)
                $display("FAIL bp_in_ready cyc %0d: got %0b, want %0b (in flight %0d)", cyc, in_ready, exp_ready, sent - recv);
            else
                pass_cnt++;
            if (held) begin
                total_cnt++;
                if ({out_valid, x_out, y_out, z_out, quadrant_out, tag_out} !== held_val)
                    $display("FAIL bp_stable cyc %0d: got %h, want %h", cyc,
                             {out_valid, x_out, y_out, z_out, quadrant_out, tag_out}, held_val);
                else
                    pass_cnt++;
            end
            if (out_valid && out_ready) begin
                exp_x = recv[0] ? -(recv + 1) : recv * 10 + 1;
                exp_y = recv[0] ? recv * 10 + 1 : recv + 1;
                exp_z = recv[0] ? 34464 : 0;
                exp_q = recv[0] ? 5 : 1;
                total_cnt++;
                if ({x_out, y_out, z_out, quadrant_out, mode_out, tag_out} !==
                    {W'(exp_x), W'(exp_y), ZW'(exp_z), 3'(exp_q), recv[0], TAG_W'(recv)})
                    $display("FAIL bp_out[%0d]: got x=%0d y=%0d z=%0d q=%0d mode=%0b tag=%0d, want x=%0d y=%0d z=%0d q=%0d mode=%0b tag=%0d",
                             recv, x_out, y_out, z_out, quadrant_out, mode_out, tag_out,
                             exp_x, exp_y, exp_z, exp_q, recv[0], recv);
                else
                    pass_cnt++;
                recv++;
            end
            held     = out_valid && !out_ready;
            held_val = {out_valid, x_out, y_out, z_out, quadrant_out, tag_out};
            if (in_valid && in_ready) sent++;
            cyc++;
        end
        total_cnt++;
        if (recv != 8)
            $display("FAIL bp_count: received %0d samples within the cycle budget, want 8", recv);
        else
            pass_cnt++;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        total_cnt++;
        if (extra != 0)
            $display("FAIL bp_duplicate: %0d extra outputs after the stream, want 0", extra);
        else
            pass_cnt++;
    endtask

    // 20 back-to-back samples with out_ready held high.
    task automatic test_throughput();
        int sent = 0;
        int recv = 0;
        int first_out = -1;
        int last_out  = -1;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && recv < 20; cyc++) begin
            @(posedge clk);
            #1;
            in_valid = (sent < 20);
            in_mode  = 1'b0;
            x_in     = W'(sent + 1000);
            y_in     = '0;
            z_in     = '0;
            tag_in   = TAG_W'(sent);
            @(negedge clk);
            total_cnt++;
            if (in_ready !== 1'b1)
                $display("FAIL tp_in_ready cyc %0d: got %0b, want 1", cyc, in_ready);
            else
                pass_cnt++;
            if (out_valid) begin
                if (recv == 0) begin
                    first_out = cyc;
                end else begin
                    total_cnt++;
                    if (cyc != last_out + 1)
                        $display("FAIL tp_gap: output %0d at cycle %0d, want %0d", recv, cyc, last_out + 1);
                    else
                        pass_cnt++;
                end
                total_cnt++;
                if ({x_out, tag_out, quadrant_out} !== {W'(recv + 1000), TAG_W'(recv), 3'd1})
                    $display("FAIL tp_out[%0d]: got x=%0d tag=%0d q=%0d, want x=%0d tag=%0d q=1",
                             recv, x_out, tag_out, quadrant_out, recv + 1000, recv % 16);
                else
                    pass_cnt++;
                last_out = cyc;
                recv++;
            end
            if (in_valid && in_ready) sent++;
        end
        total_cnt++;
        if (recv != 20 || first_out != STAGES)
            $display("FAIL tp_summary: received %0d first at cycle %0d, want 20 first at %0d", recv, first_out, STAGES);
        else
            pass_cnt++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
    endtask

    task automatic test_reset_midstream();
        int stale = 0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_mode  = 1'b0;
        x_in     = 16'sd11;
        y_in     = 16'sd22;
        z_in     = '0;
        tag_in   = 4'd1;
        @(posedge clk);
        #1;
        x_in   = 16'sd33;
        y_in   = 16'sd44;
        tag_in = 4'd2;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        total_cnt++;
        if ({out_valid, x_out, tag_out} !== {1'b1, 16'sd11, 4'd1})
            $display("FAIL rst_pre: out_valid=%0b x=%0d tag=%0d, want 1/11/1", out_valid, x_out, tag_out);
        else
            pass_cnt++;
        #2 rst = 1'b1;
        #1;
        total_cnt++;
        if ({out_valid, x_out, y_out, z_out, quadrant_out, mode_out, sat_out, tag_out} !== '0 || in_ready !== 1'b1)
            $display("FAIL rst_async: out_valid=%0b x=%0d y=%0d tag=%0d in_ready=%0b, want 0/0/0/0/1",
                     out_valid, x_out, y_out, tag_out, in_ready);
        else
            pass_cnt++;
        @(posedge clk);
        #2 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        total_cnt++;
        if (stale != 0)
            $display("FAIL rst_stale: %0d outputs after release with no input, want 0", stale);
        else
            pass_cnt++;
        run_one(1'b0, -16'sd7, 16'sd3, 18'sd5, 4'd9);
        total_cnt++;
        if (cap_seen !== 1'b1 || cap_lat != STAGES ||
            {cap_x, cap_y, cap_z, cap_q, cap_sat, cap_tag} !== {16'sd3, 16'sd7, 18'sd5, 3'd2, 1'b0, 4'd9})
            $display("FAIL rst_new: seen=%0b lat=%0d x=%0d y=%0d z=%0d q=%0d tag=%0d, want 1/%0d/3/7/5/2/9",
                     cap_seen, cap_lat, cap_x, cap_y, cap_z, cap_q, cap_tag, STAGES);
        else
            pass_cnt++;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_mode   = 1'b0;
        x_in      = '0;
        y_in      = '0;
        z_in      = '0;
        tag_in    = '0;
        out_ready = 1'b0;
        test_reset();
        test_vectoring();
        test_saturation();
        test_rotation();
        test_backpressure();
        test_throughput();
        test_reset_midstream();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", pass_cnt, total_cnt);
        $fatal(1);
    end

endmodule

// File: doc/cordic_prefold_pipe.md
Name: cordic_prefold_pipe

Overview:
- Parametrised, pipelined pre-rotation front end for the CORDIC core.
- Folds each input sample into the core's convergence range, one sample per cycle:
  - vectoring mode folds (x, y) into quadrant 1;
  - rotation mode folds angle z into [-pi/2, +pi/2] and pre-rotates (x, y) to match.
- Sits between the sample source and the first CORDIC iteration stage; valid/ready on both sides.
- Carries a quadrant code, a saturation flag and a user tag alongside the data.

Parameters:
- W, 16, width of signed x/y data.
- ZW, 18, width of signed angle; binary-angle format, pi = 2^(ZW-1), pi/2 = 2^(ZW-2).
- TAG_W, 4, width of user tag passed through unchanged.
- STAGES, 2, number of register stages (1..4); total latency in cycles when not stalled.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample this cycle.
- in_mode  in  1  0 = vectoring, 1 = rotation; sampled with the data.
- x_in  in  W  signed real part.
- y_in  in  W  signed imaginary part.
- z_in  in  ZW  signed angle.
- tag_in  in  TAG_W  user tag.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts.
- x_out  out  W  folded x.
- y_out  out  W  folded y.
- z_out  out  ZW  folded or passed angle.
- quadrant_out  out  3  1..4 in vectoring mode; 0/5/6 in rotation mode (see below).
- mode_out  out  1  mode of this sample.
- sat_out  out  1  a negation in this sample saturated.
- tag_out  out  TAG_W  tag of this sample.

Behaviour:
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Fold logic is combinational on the input and registered into stage 1. Stages 2..STAGES are pure delay registers, each with its own valid bit.
- Per-stage advance: stage k loads when stage k+1 is empty or is transferring this cycle. The last stage's downstream is out_ready.
  - in_ready = !valid[1] || stage 1 advancing, i.e. bubbles collapse.
  - Full throughput of 1 sample/cycle while out_ready = 1.
- Data registers hold their value while stalled. out_valid stays high and outputs stay stable until accepted.
- Latency: STAGES cycles from input transfer to out_valid, with no stall.
- Vectoring mode (z_out = z_in), selected by {sign x, sign y}:
  - 00: (x, y), quadrant 1.
  - 01: (-y, x), quadrant 4.
  - 10: (y, -x), quadrant 2.
  - 11: (-x, -y), quadrant 3.
- Rotation mode, with Q = 2^(ZW-2):
  - z_in >= Q: (-y, x), z_out = z_in - Q, quadrant_out 5.
  - z_in < -Q: (y, -x), z_out = z_in + Q, quadrant_out 6.
  - Otherwise pass-through, quadrant_out 0.
  - z arithmetic is done in ZW+1 bits. The result is always in range, so it is truncated back to ZW.
- Negation: -(-2^(W-1)) saturates to 2^(W-1)-1 and sets sat_out for that sample. All other negations are exact.
- Reset (async assert, synchronous release at a clk edge):
  - All valid bits clear; out_valid = 0 and in_ready = 1 on the first cycle after release.
  - x_out, y_out, z_out, tag_out, quadrant_out, mode_out and sat_out reset to 0.
  - Reset mid-stream discards every in-flight sample; nothing is replayed.
- Simultaneous input and output transfer on a full pipe: both occur, with no loss or duplication.
- in_valid with out_ready low and all stages full: in_ready = 0 and the sample is held by the source.
- mode may change on every sample; there is no pipeline flush.

Test Plan:
- Vectoring folds, STAGES=2, out_ready=1:
  - (x=100, y=-50) -> (50, 100), quad 4, 2 cycles later.
  - (-100, 50) -> (50, 100), quad 2.
  - (-100, -50) -> (100, 50), quad 3.
- Saturation: vectoring (x=-32768, y=-1) -> x_out=32767, y_out=1, quad 3, sat_out=1. Next sample (5, 5) -> sat_out=0.
- Rotation folds, ZW=18, Q=65536:
  - z=100000, (x=1000, y=0) -> (0, 1000), z_out=34464, quad 5.
  - z=-100000 -> (0, -1000), z_out=-34464, quad 6.
  - z=65535 -> pass-through, quad 0.
- Backpressure:
  - Stream 8 tagged samples (tag 0..7) with out_ready toggling 1,0,0,1 repeating -> all 8 emerge in order, none dropped or duplicated.
  - Outputs stay stable while stalled; in_ready goes low only when all stages are full.
- Full throughput: continuous in_valid with out_ready=1 for 20 cycles -> 20 outputs on consecutive cycles after a STAGES-cycle latency.
- Reset mid-stream: assert rst asynchronously with 2 samples in flight ->
  - out_valid drops immediately and all outputs are 0;
  - after release, a new sample emerges after STAGES cycles with no stale data.
